// File: rtl/write_back_controller_pkg.sv
// Shared constants for the write-back controller: FSM states and mux select codes.
package write_back_controller_pkg;

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } wb_state_e;

  localparam logic ALU_SELECT   = 1'b0;
  localparam logic CACHE_SELECT = 1'b1;

endpackage

// File: rtl/write_back_controller_stall_counter.sv
// Saturating counter of cycles during which the pipeline is stalled.
module stall_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  // Count up on each stalled cycle, holding at all-ones.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/write_back_controller.sv
// Write-back stage controller: register-file strobe, mux select and load stall/timeout.
module write_back_controller
  import write_back_controller_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned COUNTER_WIDTH  = 32,
  parameter logic        HIGH           = 1'b1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      VALID_IN,
  input  logic                      REG_WRITE_IN,
  input  logic                      MEM_READ_IN,
  input  logic [REG_ADDR_WIDTH-1:0] RD_ADDR_IN,
  input  logic                      DATA_CACHE_READY,
  output logic                      WRITE_BACK_MUX_SELECT_OUT,
  output logic                      REG_WRITE_ENABLE_OUT,
  output logic [REG_ADDR_WIDTH-1:0] RD_ADDR_OUT,
  output logic                      STALL_OUT,
  output logic                      LOAD_TIMEOUT_OUT,
  output logic [COUNTER_WIDTH-1:0]  STALL_CYCLE_COUNT_OUT
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  wb_state_e                 state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      reg_write_q, reg_write_d;
  logic [WAIT_W-1:0]         wait_q, wait_d;
  logic                      timeout_q, timeout_d;

  logic                      valid, reg_write, mem_read, ready;
  logic                      we_c, sel_c, stall_c;
  logic [REG_ADDR_WIDTH-1:0] rd_c;

  assign valid     = (VALID_IN == HIGH);
  assign reg_write = (REG_WRITE_IN == HIGH);
  assign mem_read  = (MEM_READ_IN == HIGH);
  assign ready     = (DATA_CACHE_READY == HIGH);

  // State and latched-load registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state and same-cycle write/stall decode; outputs forced low while in reset.
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    wait_d      = wait_q;
    timeout_d   = timeout_q;
    we_c        = 1'b0;
    sel_c       = ALU_SELECT;
    stall_c     = 1'b0;
    rd_c        = '0;

    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          rd_c = RD_ADDR_IN;
          if (mem_read) begin
            sel_c = CACHE_SELECT;
            if (ready) begin
              we_c = reg_write && (RD_ADDR_IN != '0);
            end else begin
              stall_c     = 1'b1;
              rd_d        = RD_ADDR_IN;
              reg_write_d = reg_write;
              wait_d      = '0;
              state_d     = ST_LOAD_WAIT;
            end
          end else begin
            we_c = reg_write && (RD_ADDR_IN != '0);
          end
        end
      end
      ST_LOAD_WAIT: begin
        sel_c = CACHE_SELECT;
        rd_c  = rd_q;
        if (ready) begin
          we_c    = reg_write_q && (rd_q != '0);
          state_d = ST_IDLE;
        end else begin
          // The last permitted empty wait cycle still stalls; the load is dropped after it.
          stall_c = 1'b1;
          wait_d  = wait_q + WAIT_W'(1);
          if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!RST_N) begin
      we_c    = 1'b0;
      sel_c   = ALU_SELECT;
      stall_c = 1'b0;
      rd_c    = '0;
    end
  end

  stall_counter #(
    .WIDTH (COUNTER_WIDTH)
  ) u_stall_counter (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .inc_i   (stall_c),
    .count_o (STALL_CYCLE_COUNT_OUT)
  );

  assign WRITE_BACK_MUX_SELECT_OUT = sel_c;
  assign REG_WRITE_ENABLE_OUT      = we_c ? HIGH : ~HIGH;
  assign RD_ADDR_OUT               = rd_c;
  assign STALL_OUT                 = stall_c ? HIGH : ~HIGH;
  assign LOAD_TIMEOUT_OUT          = timeout_q ? HIGH : ~HIGH;

endmodule

// File: tb/tb_write_back_controller.sv
// Self-checking bench for write_back_controller with an expected-write scoreboard.
module tb_write_back_controller;

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;
  localparam int unsigned TO = 4;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid, reg_write, mem_read, ready;
  logic [AW-1:0] rd_addr;
  logic          sel, we, stall, timeout;
  logic [AW-1:0] rd_out;
  logic [CW-1:0] cnt;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [AW:0]   sb_q[$];
  logic [CW-1:0] exp_cnt;

  write_back_controller #(
    .REG_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES (TO),
    .COUNTER_WIDTH  (CW),
    .HIGH           (1'b1)
  ) dut (
    .CLK                       (clk),
    .RST_N                     (rst_n),
    .VALID_IN                  (valid),
    .REG_WRITE_IN              (reg_write),
    .MEM_READ_IN               (mem_read),
    .RD_ADDR_IN                (rd_addr),
    .DATA_CACHE_READY          (ready),
    .WRITE_BACK_MUX_SELECT_OUT (sel),
    .REG_WRITE_ENABLE_OUT      (we),
    .RD_ADDR_OUT               (rd_out),
    .STALL_OUT                 (stall),
    .LOAD_TIMEOUT_OUT          (timeout),
    .STALL_CYCLE_COUNT_OUT     (cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic mr,
                       input logic [AW-1:0] rd, input logic rdy);
    valid     = v;
    reg_write = rw;
    mem_read  = mr;
    rd_addr   = rd;
    ready     = rdy;
  endtask

  task automatic push_wr(input logic s, input logic [AW-1:0] rd);
    sb_q.push_back({s, rd});
  endtask

  task automatic at_neg(input string tag, input logic exp_stall);
    @(negedge clk);
    check_eq({tag, ":stall"}, 32'(stall), 32'(exp_stall));
  endtask

  task automatic end_cyc(input string tag, input logic exp_stall);
    @(posedge clk);
    if (exp_stall && (exp_cnt != CNT_MAX)) exp_cnt = exp_cnt + CW'(1);
    #1;
    check_eq({tag, ":cnt"}, 32'(cnt), 32'(exp_cnt));
    check_eq({tag, ":pend"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic one(input string tag, input logic exp_stall);
    at_neg(tag, exp_stall);
    end_cyc(tag, exp_stall);
  endtask

  // Every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && we) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_we", 32'(we), 32'd0);
      end else begin
        logic [AW:0] e;
        e = sb_q.pop_front();
        check_eq("wr_addr", 32'(rd_out), 32'(e[AW-1:0]));
        check_eq("wr_sel", 32'(sel), 32'(e[AW]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    exp_cnt = '0;
    drive(1'b1, 1'b1, 1'b0, 5'd5, 1'b1);
    @(negedge clk);
    check_eq("rst:we", 32'(we), 32'd0);
    check_eq("rst:sel", 32'(sel), 32'd0);
    check_eq("rst:rd", 32'(rd_out), 32'd0);
    check_eq("rst:stall", 32'(stall), 32'd0);
    check_eq("rst:timeout", 32'(timeout), 32'd0);
    check_eq("rst:cnt", 32'(cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ALU write in the first cycle out of reset
    drive(1'b1, 1'b1, 1'b0, 5'd5, 1'b0);
    push_wr(1'b0, 5'd5);
    one("alu", 1'b0);

    // no valid instruction: write outputs stay low
    drive(1'b0, 1'b1, 1'b0, 5'd3, 1'b0);
    at_neg("novalid", 1'b0);
    check_eq("novalid:rd", 32'(rd_out), 32'd0);
    check_eq("novalid:sel", 32'(sel), 32'd0);
    end_cyc("novalid", 1'b0);

    drive(1'b1, 1'b0, 1'b0, 5'd6, 1'b0);
    one("alu_norw", 1'b0);

    // cache ready without a load is ignored
    drive(1'b0, 1'b0, 1'b0, 5'd2, 1'b1);
    one("rdy_idle", 1'b0);
    drive(1'b1, 1'b1, 1'b0, 5'd2, 1'b1);
    push_wr(1'b0, 5'd2);
    one("alu_rdy", 1'b0);

    // load hit
    drive(1'b1, 1'b1, 1'b1, 5'd7, 1'b1);
    push_wr(1'b1, 5'd7);
    one("hit", 1'b0);

    // load miss, ready three cycles later; inputs during the wait are ignored
    drive(1'b1, 1'b1, 1'b1, 5'd9, 1'b0);
    at_neg("miss0", 1'b1);
    check_eq("miss0:sel", 32'(sel), 32'd1);
    end_cyc("miss0", 1'b1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 5'd12, 1'b0);
      at_neg("miss_w", 1'b1);
      check_eq("miss_w:sel", 32'(sel), 32'd1);
      end_cyc("miss_w", 1'b1);
    end
    drive(1'b0, 1'b0, 1'b0, 5'd12, 1'b1);
    push_wr(1'b1, 5'd9);
    one("miss_rdy", 1'b0);
    check_eq("miss:cnt3", 32'(cnt), 32'd3);
    drive(1'b1, 1'b1, 1'b0, 5'd4, 1'b0);
    push_wr(1'b0, 5'd4);
    one("after_miss", 1'b0);

    // destination x0 and loads without reg_write never write, stalls unchanged
    drive(1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    one("x0_alu", 1'b0);
    drive(1'b1, 1'b1, 1'b1, 5'd0, 1'b1);
    one("x0_hit", 1'b0);
    drive(1'b1, 1'b1, 1'b1, 5'd0, 1'b0);
    one("x0_miss", 1'b1);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    one("x0_rdy", 1'b0);
    drive(1'b1, 1'b0, 1'b1, 5'd8, 1'b0);
    one("norw_miss", 1'b1);
    drive(1'b0, 1'b0, 1'b0, 5'd8, 1'b1);
    one("norw_rdy", 1'b0);

    // timeout: ready never arrives
    drive(1'b1, 1'b1, 1'b1, 5'd10, 1'b0);
    one("to_miss", 1'b1);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < int'(TO); i++) begin
      at_neg("to_w", 1'b1);
      check_eq("to_w:timeout", 32'(timeout), 32'd0);
      end_cyc("to_w", 1'b1);
    end
    at_neg("to_idle", 1'b0);
    check_eq("to_idle:timeout", 32'(timeout), 32'd1);
    end_cyc("to_idle", 1'b0);
    drive(1'b1, 1'b1, 1'b0, 5'd11, 1'b0);
    push_wr(1'b0, 5'd11);
    one("to_alu", 1'b0);
    check_eq("to_sticky", 32'(timeout), 32'd1);

    // ready on the last allowed wait cycle still writes; counter saturates
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, AW'(16 + i), 1'b0);
      one("sat_miss", 1'b1);
      for (int j = 0; j < int'(TO) - 1; j++) begin
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        one("sat_w", 1'b1);
      end
      drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
      push_wr(1'b1, AW'(16 + i));
      one("sat_rdy", 1'b0);
    end
    check_eq("sat:cnt", 32'(cnt), 32'd15);

    // reset during the second wait cycle abandons the load
    drive(1'b1, 1'b1, 1'b1, 5'd13, 1'b0);
    one("rst_miss", 1'b1);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    one("rst_w1", 1'b1);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    exp_cnt = '0;
    at_neg("rst_w2", 1'b0);
    check_eq("rst_w2:we", 32'(we), 32'd0);
    check_eq("rst_w2:sel", 32'(sel), 32'd0);
    check_eq("rst_w2:rd", 32'(rd_out), 32'd0);
    check_eq("rst_w2:timeout", 32'(timeout), 32'd0);
    end_cyc("rst_w2", 1'b0);
    rst_n = 1'b1;
    one("rst_rel", 1'b0);
    drive(1'b1, 1'b1, 1'b0, 5'd14, 1'b0);
    push_wr(1'b0, 5'd14);
    one("rst_alu", 1'b0);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
